uart_tx_sched: RTL

Shares one uart_tx serializer among N_REQ byte producers using round-robin arbitration. Generates the baud tick from a programmable divisor. Sequences each frame through tx_start, waiting for tx_done, and an inter-frame gap, with a watchdog on tx_done. Sits between the producers and the uart_tx DUT, driving tick, tx_start and tx_data and sampling tx_done.

---
 rtl/uart_sched_pkg.sv | 41 ++++
 rtl/uart_baud_gen.sv | 30 +++
 rtl/uart_tx_sched.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and the round-robin picker for the uart_tx scheduler.
// Requester count is capped at 16, so indices fit in 4 bits.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_DONE,
        GAP
    } state_e;

    localparam int MAX_REQ = 16;
    localparam int IDX_W   = 4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // Scan from last+1 with wrap at n; the first set bit wins.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input logic [IDX_W-1:0]   last,
        input int                 n
    );
        rr_pick_t r;
        int       i;
        r = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                i = (int'(last) + k) % n;
                if (!r.found && valid[IDX_W'(i)]) begin
                    r.found = 1'b1;
                    r.idx   = IDX_W'(i);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running baud divider: one tick every baud_div+1 clocks.
// A divisor lowered below the count wraps at the next compare.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] div_cnt;
    logic             hit;

    // >= rather than == so a shrunken divisor never strands the count
    assign hit  = (div_cnt >= baud_div);
    assign tick = hit & ~rst;

    // Divider counter, cleared after each tick
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (hit) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx among N_REQ producers.
// Sequences start, done wait with watchdog, and an inter-frame gap.
module uart_tx_sched
    import uart_sched_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int N_REQ         = 4,
    parameter int DIV_W         = 16,
    parameter int GAP_TICKS     = 1,
    parameter int TIMEOUT_TICKS = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIV_W-1:0]           baud_div,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tick,
    output logic                       tx_start,
    output logic [DATA_BITS-1:0]       tx_data,
    input  logic                       tx_done,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int GW = $clog2(N_REQ);
    localparam int CNT_MAX =
        (TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST =
        CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    state_e           state;
    state_e           state_n;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] tick_cnt_n;
    logic [GW-1:0]    last_grant;
    logic [GW-1:0]    win;
    logic             take;
    rr_pick_t         pick;

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .tick     (tick)
    );

    // Winner among valid requesters, starting after the last grant
    always_comb begin
        pick = rr_pick(MAX_REQ'(req_valid),
                       IDX_W'(last_grant), N_REQ);
        win  = pick.idx[GW-1:0];
    end

    assign busy = (state != IDLE);

    // Next state, tick counter and strobes for the frame sequence
    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick_cnt;
        req_ready   = '0;
        tx_start    = 1'b0;
        timeout_err = 1'b0;
        take        = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick.found) begin
                    req_ready[win] = 1'b1;
                    take           = 1'b1;
                    state_n        = START;
                end
            end
            START: begin
                tx_start = 1'b1;
                if (tick) begin
                    state_n    = WAIT_DONE;
                    tick_cnt_n = '0;
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_n    = GAP;
                    tick_cnt_n = '0;
                end else if (tick) begin
                    if (tick_cnt == TO_LAST) begin
                        timeout_err = 1'b1;
                        state_n     = GAP;
                        tick_cnt_n  = '0;
                    end else begin
                        tick_cnt_n = tick_cnt + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (GAP_TICKS == 0) begin
                    state_n = IDLE;
                end else if (tick) begin
                    if (tick_cnt == GAP_LAST) begin
                        state_n    = IDLE;
                        tick_cnt_n = '0;
                    end else begin
                        tick_cnt_n = tick_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (rst) begin
            req_ready   = '0;
            tx_start    = 1'b0;
            timeout_err = 1'b0;
            take        = 1'b0;
        end
    end

    // State and tick counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
        end
    end

    // Capture byte and requester on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(N_REQ - 1);
            grant_id   <= '0;
            tx_data    <= '0;
        end else if (take) begin
            last_grant <= win;
            grant_id   <= win;
            tx_data    <= req_data[win*DATA_BITS +: DATA_BITS];
        end
    end

endmodule
